parser_pipeline_top: RTL

- Parametrised successor to the fixed three-layer parser top.
- Chains LAYER_NUM Parser_Layer instances behind a local layer-0 configuration stage.
- Adds three features the fixed version lacks: full rule readback with timeout, per-layer bypass, and per-layer packet counters.
- Sits between packet ingress (head/meta slices with tags) and the match-action stage. The rule bus is the CSR path.

---
 rtl/parser_pipeline_top.sv | 381 ++++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/parser_pipeline_top.sv
// Parametrised parser pipeline: local layer-0 config stage feeding LAYER_NUM chained
// Parser_Layer stages, with per-layer bypass, packet counters and rule readback with timeout.

package parser_pkg;
  localparam int HEAD_WIDTH        = 64;
  localparam int META_WIDTH        = 32;
  localparam int TAG_WIDTH         = 4;
  localparam int TAG_VALID         = 0;
  localparam int TAG_START         = 1;
  localparam int TYPE_NUM          = 2;
  localparam int KEY_NUM           = 2;
  localparam int TYPE_OFFSET_WIDTH = 6;
  localparam int KEY_OFFSET_WIDTH  = 6;
  localparam int SHIFT_WIDTH       = 8;

  localparam logic [2:0] INFO_TYPE   = 3'd2;
  localparam logic [2:0] INFO_KEY    = 3'd3;
  localparam logic [2:0] INFO_HSHIFT = 3'd4;
  localparam logic [2:0] INFO_MSHIFT = 3'd5;
  localparam logic [2:0] INFO_BYPASS = 3'd6;
  localparam logic [2:0] INFO_CNT    = 3'd7;

  function automatic logic [7:0] rule_layer(input logic [31:0] addr);
    return addr[31:24];
  endfunction

  function automatic logic [2:0] rule_info(input logic [31:0] addr);
    return addr[18:16];
  endfunction

  function automatic logic [7:0] rule_idx(input logic [31:0] addr);
    return addr[7:0];
  endfunction

  typedef struct packed {
    logic [HEAD_WIDTH+TAG_WIDTH-1:0]                head;
    logic [META_WIDTH+TAG_WIDTH-1:0]                meta;
    logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]     type_offset;
    logic [KEY_NUM-1:0][KEY_OFFSET_WIDTH:0]         key_offset;
    logic [SHIFT_WIDTH-1:0]                         head_shift;
    logic [SHIFT_WIDTH-1:0]                         meta_shift;
  } layer_info_t;
endpackage

// One parser stage: shifts head/meta by the previous stage's settings, folds the key
// word into meta, and presents its own rule registers to the next stage. Latency 1.
module Parser_Layer
  import parser_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  layer_info_t info_in,
  output layer_info_t info_out,
  input  logic        rule_wren,
  input  logic [31:0] rule_waddr,
  input  logic [31:0] rule_wdata,
  input  logic        rule_rden,
  input  logic [31:0] rule_raddr,
  output logic        rule_rdata_valid,
  output logic [31:0] rule_rdata
);
  logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0] type_offset;
  logic [KEY_NUM-1:0][KEY_OFFSET_WIDTH:0]     key_offset;
  logic [SHIFT_WIDTH-1:0]                     head_shift;
  logic [SHIFT_WIDTH-1:0]                     meta_shift;
  logic [HEAD_WIDTH-1:0]                      head_data, head_next, key_src;
  logic [META_WIDTH-1:0]                      meta_data, meta_next;
  logic [KEY_OFFSET_WIDTH:0]                  key_pos;
  logic                                       rd_hit;
  logic [31:0]                                rd_word;
  logic                                       unused_bits;

  assign unused_bits = ^{rule_waddr[31:19], rule_waddr[15:8], rule_raddr[31:19], rule_raddr[15:8],
                         rule_wdata[31:17], rule_wdata[15:8], info_in.type_offset[1],
                         info_in.key_offset[1]};

  always_comb begin
    head_data = info_in.head[TAG_WIDTH +: HEAD_WIDTH];
    meta_data = info_in.meta[TAG_WIDTH +: META_WIDTH];
    key_pos   = (KEY_OFFSET_WIDTH+1)'(info_in.type_offset[0])
              + {1'b0, info_in.key_offset[0][KEY_OFFSET_WIDTH-1:0]};
    key_src   = head_data >> key_pos;
    head_next = head_data << info_in.head_shift;
    meta_next = meta_data << info_in.meta_shift;
    if (info_in.key_offset[0][KEY_OFFSET_WIDTH])
      meta_next = meta_next ^ key_src[META_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      info_out <= '0;
    end else begin
      info_out.head        <= {head_next, info_in.head[TAG_WIDTH-1:0]};
      info_out.meta        <= {meta_next, info_in.meta[TAG_WIDTH-1:0]};
      info_out.type_offset <= type_offset;
      info_out.key_offset  <= key_offset;
      info_out.head_shift  <= head_shift;
      info_out.meta_shift  <= meta_shift;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      type_offset <= '0;
      key_offset  <= '0;
      head_shift  <= '0;
      meta_shift  <= '0;
    end else if (rule_wren) begin
      case (rule_info(rule_waddr))
        INFO_TYPE:
          for (int i = 0; i < TYPE_NUM; i++)
            if (rule_idx(rule_waddr) == 8'(i))
              type_offset[i] <= rule_wdata[TYPE_OFFSET_WIDTH-1:0];
        INFO_KEY:
          for (int i = 0; i < KEY_NUM; i++)
            if (rule_idx(rule_waddr) == 8'(i))
              key_offset[i] <= {rule_wdata[16], rule_wdata[KEY_OFFSET_WIDTH-1:0]};
        INFO_HSHIFT: head_shift <= rule_wdata[SHIFT_WIDTH-1:0];
        INFO_MSHIFT: meta_shift <= rule_wdata[SHIFT_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // Unimplemented info types and indices stay silent; the top's timeout covers them.
  always_comb begin
    rd_hit  = 1'b0;
    rd_word = '0;
    case (rule_info(rule_raddr))
      INFO_TYPE:
        for (int i = 0; i < TYPE_NUM; i++)
          if (rule_idx(rule_raddr) == 8'(i)) begin
            rd_hit  = 1'b1;
            rd_word = 32'(type_offset[i]);
          end
      INFO_KEY:
        for (int i = 0; i < KEY_NUM; i++)
          if (rule_idx(rule_raddr) == 8'(i)) begin
            rd_hit  = 1'b1;
            rd_word = 32'(key_offset[i]);
          end
      INFO_HSHIFT: begin
        rd_hit  = 1'b1;
        rd_word = 32'(head_shift);
      end
      INFO_MSHIFT: begin
        rd_hit  = 1'b1;
        rd_word = 32'(meta_shift);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rule_rdata_valid <= 1'b0;
      rule_rdata       <= '0;
    end else begin
      rule_rdata_valid <= rule_rden && rd_hit;
      if (rule_rden && rd_hit)
        rule_rdata <= rd_word;
    end
  end
endmodule

// state     | meaning
// ST_IDLE   | accepting reads; layer-0 and unmapped reads answered next cycle
// ST_WAIT   | read forwarded to a layer; waiting for its response or the timeout
module parser_pipeline_top
  import parser_pkg::*;
#(
  parameter int          LAYER_NUM  = 3,
  parameter int          RD_TIMEOUT = 32,
  parameter int          CNT_WIDTH  = 32,
  parameter logic [31:0] ERR_WORD   = 32'hDEAD_BEEF
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_rule_wren,
  input  logic                            i_rule_rden,
  input  logic [31:0]                     i_rule_addr,
  input  logic [31:0]                     i_rule_wdata,
  output logic                            o_rule_rdata_valid,
  output logic [31:0]                     o_rule_rdata,
  output logic                            o_rd_busy,
  input  logic [HEAD_WIDTH+TAG_WIDTH-1:0] i_head,
  input  logic [META_WIDTH+TAG_WIDTH-1:0] i_meta,
  output logic [HEAD_WIDTH+TAG_WIDTH-1:0] o_head,
  output logic [META_WIDTH+TAG_WIDTH-1:0] o_meta
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;
  localparam int         TMR_W   = $clog2(RD_TIMEOUT + 1);

  layer_info_t                                layer_info [0:LAYER_NUM];
  logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0] l0_type_offset;
  logic [KEY_NUM-1:0][KEY_OFFSET_WIDTH:0]     l0_key_offset;
  logic [SHIFT_WIDTH-1:0]                     l0_head_shift;
  logic [SHIFT_WIDTH-1:0]                     l0_meta_shift;
  logic [LAYER_NUM:1]                         bypass;
  logic [CNT_WIDTH-1:0]                       cnt [1:LAYER_NUM];

  logic [7:0]         req_layer;
  logic [2:0]         req_info;
  logic [7:0]         req_idx;
  logic               l0_wr, cnt_clr;
  logic [LAYER_NUM:1] lay_wren, lay_rden, lay_rvalid, hit;
  logic [31:0]        lay_rdata [1:LAYER_NUM];

  logic [0:0]         state;
  logic [TMR_W-1:0]   timer;
  logic [7:0]         rd_layer;
  logic [31:0]        rd_addr_q;
  logic [31:0]        l0_rdata;
  logic               sel_valid;
  logic [31:0]        sel_rdata;
  logic               unused_bits;

  assign req_layer = rule_layer(i_rule_addr);
  assign req_info  = rule_info(i_rule_addr);
  assign req_idx   = rule_idx(i_rule_addr);
  assign l0_wr     = i_rule_wren && (req_layer == 8'd0);
  assign cnt_clr   = l0_wr && (req_info == INFO_CNT);

  assign unused_bits = ^{i_rule_addr[23:19], i_rule_addr[15:8],
                         layer_info[LAYER_NUM].type_offset, layer_info[LAYER_NUM].key_offset,
                         layer_info[LAYER_NUM].head_shift, layer_info[LAYER_NUM].meta_shift};

  assign layer_info[0] = '{head: i_head, meta: i_meta, type_offset: l0_type_offset,
                           key_offset: l0_key_offset, head_shift: l0_head_shift,
                           meta_shift: l0_meta_shift};

  for (genvar k = 1; k <= LAYER_NUM; k++) begin : g_layer
    layer_info_t lay_out;
    layer_info_t bp_q;

    assign lay_wren[k] = i_rule_wren && (req_layer == 8'(k));

    Parser_Layer u_layer (
      .clk              (i_clk),
      .rst_n            (i_rst_n),
      .info_in          (layer_info[k-1]),
      .info_out         (lay_out),
      .rule_wren        (lay_wren[k]),
      .rule_waddr       (i_rule_addr),
      .rule_wdata       (i_rule_wdata),
      .rule_rden        (lay_rden[k]),
      .rule_raddr       (rd_addr_q),
      .rule_rdata_valid (lay_rvalid[k]),
      .rule_rdata       (lay_rdata[k])
    );

    // Same single-cycle latency as the layer, so bypass never shifts slice alignment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) bp_q <= '0;
      else          bp_q <= layer_info[k-1];
    end

    assign layer_info[k] = bypass[k] ? bp_q : lay_out;
    assign hit[k]        = layer_info[k].head[TAG_VALID] && layer_info[k].head[TAG_START];
  end

  assign o_head    = layer_info[LAYER_NUM].head;
  assign o_meta    = layer_info[LAYER_NUM].meta;
  assign o_rd_busy = (state == ST_WAIT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      l0_type_offset <= '0;
      l0_key_offset  <= '0;
      l0_head_shift  <= '0;
      l0_meta_shift  <= '0;
      bypass         <= '0;
    end else if (l0_wr) begin
      case (req_info)
        INFO_TYPE:
          for (int i = 0; i < TYPE_NUM; i++)
            if (req_idx == 8'(i)) l0_type_offset[i] <= i_rule_wdata[TYPE_OFFSET_WIDTH-1:0];
        INFO_KEY:
          for (int i = 0; i < KEY_NUM; i++)
            if (req_idx == 8'(i))
              l0_key_offset[i] <= {i_rule_wdata[16], i_rule_wdata[KEY_OFFSET_WIDTH-1:0]};
        INFO_HSHIFT: l0_head_shift <= i_rule_wdata[SHIFT_WIDTH-1:0];
        INFO_MSHIFT: l0_meta_shift <= i_rule_wdata[SHIFT_WIDTH-1:0];
        INFO_BYPASS: bypass        <= i_rule_wdata[LAYER_NUM:1];
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 1; k <= LAYER_NUM; k++) cnt[k] <= '0;
    end else begin
      for (int k = 1; k <= LAYER_NUM; k++) begin
        if (cnt_clr)
          cnt[k] <= '0;
        else if (hit[k] && (cnt[k] != {CNT_WIDTH{1'b1}}))
          cnt[k] <= cnt[k] + 1'b1;
      end
    end
  end

  always_comb begin
    l0_rdata = '0;
    case (req_info)
      INFO_TYPE:
        for (int i = 0; i < TYPE_NUM; i++)
          if (req_idx == 8'(i)) l0_rdata = 32'(l0_type_offset[i]);
      INFO_KEY:
        for (int i = 0; i < KEY_NUM; i++)
          if (req_idx == 8'(i)) l0_rdata = 32'(l0_key_offset[i]);
      INFO_HSHIFT: l0_rdata = 32'(l0_head_shift);
      INFO_MSHIFT: l0_rdata = 32'(l0_meta_shift);
      INFO_BYPASS: l0_rdata = 32'(bypass);
      INFO_CNT:
        for (int k = 1; k <= LAYER_NUM; k++)
          if (req_idx == 8'(k)) l0_rdata = 32'(cnt[k]);
      default: ;
    endcase
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_rdata = '0;
    for (int k = 1; k <= LAYER_NUM; k++)
      if (rd_layer == 8'(k)) begin
        sel_valid = lay_rvalid[k];
        sel_rdata = lay_rdata[k];
      end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state              <= ST_IDLE;
      timer              <= '0;
      rd_layer           <= '0;
      rd_addr_q          <= '0;
      lay_rden           <= '0;
      o_rule_rdata_valid <= 1'b0;
      o_rule_rdata       <= '0;
    end else begin
      o_rule_rdata_valid <= 1'b0;
      lay_rden           <= '0;
      case (state)
        ST_IDLE: begin
          if (i_rule_rden) begin
            if (req_layer == 8'd0) begin
              o_rule_rdata_valid <= 1'b1;
              o_rule_rdata       <= l0_rdata;
            end else if (req_layer <= 8'(LAYER_NUM)) begin
              for (int k = 1; k <= LAYER_NUM; k++)
                lay_rden[k] <= (req_layer == 8'(k));
              rd_layer  <= req_layer;
              rd_addr_q <= i_rule_addr;
              timer     <= TMR_W'(RD_TIMEOUT - 1);
              state     <= ST_WAIT;
            end else begin
              o_rule_rdata_valid <= 1'b1;
              o_rule_rdata       <= ERR_WORD;
            end
          end
        end
        ST_WAIT: begin
          if (sel_valid) begin
            o_rule_rdata_valid <= 1'b1;
            o_rule_rdata       <= sel_rdata;
            state              <= ST_IDLE;
          end else if (timer == '0) begin
            o_rule_rdata_valid <= 1'b1;
            o_rule_rdata       <= ERR_WORD;
            state              <= ST_IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
